sprite_hit_check: RTL and testbench

Frame-rate collision detector for the PPU sprite layer. On a start pulse it reads all sprite entries through the spare read port of the sprite RAM and caches the position, class and valid fields. It then tests every unordered sprite pair for bounding-box overlap under the game's class rules and publishes a per-sprite hit bitmap that the CPU-side logic reads once per frame. It runs in the 100 MHz PPU compute domain, alongside the scanline sprite fetch.

---
 rtl/sprite_hit_check.sv | 167 ++++++++++++++++
 tb/tb_sprite_hit_check.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_hit_check.sv
// Purpose: frame-rate sprite collision detector; caches sprite RAM, tests all pairs, publishes hit bitmap.
// Latency: SPRITE_NUM + 2 + SPRITE_NUM*(SPRITE_NUM-1)/2 cycles from accepted start to hitCheckDone.
// Backpressure: none; hitCheckStart is ignored while busy and allSpriteHit holds until the next done.
module sprite_hit_check #(
    parameter int SPRITE_NUM = 64,
    parameter int INDEX_W    = 6,
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  hitCheckStart,
    output logic [INDEX_W-1:0]    hitCheck_spriteViewRamIndex,
    input  logic [31:0]           spriteViewRamDataO_hitCheck,
    output logic [SPRITE_NUM-1:0] allSpriteHit,
    output logic                  hitCheckBusy,
    output logic                  hitCheckDone
);

    localparam int                 CNT_W    = INDEX_W + 1;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(SPRITE_NUM - 1);
    localparam logic [INDEX_W-1:0] PEN_IDX  = INDEX_W'(SPRITE_NUM - 2);
    localparam logic [CNT_W-1:0]   LOAD_END = CNT_W'(SPRITE_NUM);
    localparam logic [8:0]         W9       = 9'(SPRITE_W);
    localparam logic [8:0]         H9       = 9'(SPRITE_H);

    // Cached subset of a sprite RAM word; tile and spare attribute bits are dropped.
    typedef struct packed {
        logic       vld;
        logic [1:0] cls;
        logic [7:0] y;
        logic [7:0] x;
    } ent_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CMP,
        ST_DONE
    } state_t;

    state_t                  state_q;
    ent_t                    cache_q [SPRITE_NUM];
    logic [SPRITE_NUM-1:0]   work_q;
    logic [SPRITE_NUM-1:0]   all_hit_q;
    logic [CNT_W-1:0]        ld_cnt_q;
    logic [INDEX_W-1:0]      addr_q;
    logic [INDEX_W-1:0]      pi_q;
    logic [INDEX_W-1:0]      pj_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    cache_we;
    logic [INDEX_W-1:0]      cache_wr_idx;
    ent_t                    ea;
    ent_t                    eb;
    logic                    class_ok;
    logic                    ovl_x;
    logic                    ovl_y;
    logic                    pair_hit;
    logic                    unused_bits;

    assign unused_bits = ^{spriteViewRamDataO_hitCheck[30], spriteViewRamDataO_hitCheck[27:16]};

    // Read data for slot k arrives while ld_cnt_q == k+1, so the write trails the counter by one.
    assign cache_we     = (state_q == ST_LOAD) && (ld_cnt_q != '0);
    assign cache_wr_idx = INDEX_W'(ld_cnt_q - CNT_W'(1));

    // Sprite cache: filled once per check during LOAD, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < SPRITE_NUM; k++) begin
                cache_q[k] <= '0;
            end
        end else if (cache_we) begin
            cache_q[cache_wr_idx] <= '{vld: spriteViewRamDataO_hitCheck[31],
                                       cls: spriteViewRamDataO_hitCheck[29:28],
                                       y:   spriteViewRamDataO_hitCheck[15:8],
                                       x:   spriteViewRamDataO_hitCheck[7:0]};
        end
    end

    // Pair test: class rule plus 9-bit box overlap so edges near 255 never wrap.
    always_comb begin
        ea = cache_q[pi_q];
        eb = cache_q[pj_q];
        class_ok = 1'b0;
        case ({ea.cls, eb.cls})
            4'b0010, 4'b1000,             // player / enemy
            4'b0011, 4'b1100,             // player / enemy bullet
            4'b0110, 4'b1001: class_ok = 1'b1; // player bullet / enemy
            default:          class_ok = 1'b0;
        endcase
        ovl_x = ({1'b0, ea.x} < ({1'b0, eb.x} + W9)) && ({1'b0, eb.x} < ({1'b0, ea.x} + W9));
        ovl_y = ({1'b0, ea.y} < ({1'b0, eb.y} + H9)) && ({1'b0, eb.y} < ({1'b0, ea.y} + H9));
        pair_hit = ea.vld && eb.vld && class_ok && ovl_x && ovl_y;
    end

    // Control FSM: IDLE -> LOAD (address sweep) -> CMP (one pair per cycle) -> DONE (publish).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            all_hit_q <= '0;
            ld_cnt_q  <= '0;
            addr_q    <= '0;
            pi_q      <= '0;
            pj_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hitCheckStart) begin
                        state_q  <= ST_LOAD;
                        addr_q   <= '0;
                        work_q   <= '0;
                        ld_cnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (addr_q != LAST_IDX) begin
                        addr_q <= addr_q + INDEX_W'(1);
                    end
                    if (ld_cnt_q == LOAD_END) begin
                        state_q <= ST_CMP;
                        pi_q    <= '0;
                        pj_q    <= INDEX_W'(1);
                    end else begin
                        ld_cnt_q <= ld_cnt_q + CNT_W'(1);
                    end
                end
                ST_CMP: begin
                    if (pair_hit) begin
                        work_q[pi_q] <= 1'b1;
                        work_q[pj_q] <= 1'b1;
                    end
                    if (pj_q == LAST_IDX) begin
                        if (pi_q == PEN_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            pi_q <= pi_q + INDEX_W'(1);
                            pj_q <= pi_q + INDEX_W'(2);
                        end
                    end else begin
                        pj_q <= pj_q + INDEX_W'(1);
                    end
                end
                ST_DONE: begin
                    all_hit_q <= work_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hitCheck_spriteViewRamIndex = addr_q;
    assign allSpriteHit                = all_hit_q;
    assign hitCheckBusy                = busy_q;
    assign hitCheckDone                = done_q;

endmodule

// File: tb/tb_sprite_hit_check.sv
// Purpose: directed-vector bench for sprite_hit_check with a queued expected-bitmap scoreboard.
// Latency: expects done 2082 cycles after each accepted start (SPRITE_NUM=64).
// Backpressure: n/a; models the sprite RAM as a synchronous-read array.
module tb_sprite_hit_check;

    localparam int BUSY_LEN = 2082;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [5:0]  addr;
    logic [31:0] rd_dat;
    logic [63:0] hit;
    logic        busy;
    logic        done;

    logic [31:0] ram [64];

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] last_exp = '0;
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    // Synchronous-read sprite RAM
    always @(posedge clk) rd_dat <= ram[addr];

    sprite_hit_check dut (
        .clk                         (clk),
        .rstn                        (rstn),
        .hitCheckStart               (start),
        .hitCheck_spriteViewRamIndex (addr),
        .spriteViewRamDataO_hitCheck (rd_dat),
        .allSpriteHit                (hit),
        .hitCheckBusy                (busy),
        .hitCheckDone                (done)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic v, input logic [1:0] c,
                                        input logic [7:0] x, input logic [7:0] y);
        return {v, 1'b0, c, 4'b0000, 8'hA5, y, x};
    endfunction

    task automatic clear_ram();
        for (int k = 0; k < 64; k++) ram[k] = 32'h00A5_0000;
    endtask

    // Monitor: pops the expected bitmap on each done pulse and checks timing and hold behaviour
    always @(negedge clk) begin
        if (!rstn) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
            last_exp  = '0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (busy_cnt % 256 == 0) check64("hold_during_busy", hit, last_exp);
            end
            if (done) begin
                check64("busy_len", 64'(busy_cnt), 64'(BUSY_LEN));
                check64("busy_fall_at_done", {62'd0, prev_busy, busy}, 64'h2);
                check64("done_single_cycle", {63'd0, prev_done}, 64'h0);
                if (exp_q.size() == 0) begin
                    check64("unexpected_done", 64'h1, 64'h0);
                end else begin
                    last_exp = exp_q.pop_front();
                    check64("bitmap", hit, last_exp);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic start_pulse(input int len);
        @(negedge clk);
        start = 1'b1;
        repeat (len) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2300) begin
            @(negedge clk);
            n++;
        end
        check64("done_timeout", {63'd0, done}, 64'h1);
    endtask

    task automatic run_check(input logic [63:0] exp, input int len);
        exp_q.push_back(exp);
        start_pulse(len);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        clear_ram();
        #12;
        check64("rst_hit",  hit, 64'h0);
        check64("rst_busy", {63'd0, busy}, 64'h0);
        check64("rst_done", {63'd0, done}, 64'h0);
        check64("rst_addr", {58'd0, addr}, 64'h0);
        @(posedge clk);
        #2 rstn = 1'b1;

        // All invalid
        run_check(64'h0, 1);

        // Player 0 vs enemy 5 overlapping; start held for three cycles
        ram[0] = ent(1'b1, 2'd0, 8'd100, 8'd100);
        ram[5] = ent(1'b1, 2'd2, 8'd115, 8'd115);
        run_check(64'h21, 3);

        // Exact edge: no overlap
        ram[5] = ent(1'b1, 2'd2, 8'd116, 8'd100);
        run_check(64'h0, 1);

        // Non-hitting class pairs
        clear_ram();
        ram[2]  = ent(1'b1, 2'd2, 8'd50, 8'd50);
        ram[3]  = ent(1'b1, 2'd2, 8'd50, 8'd50);
        ram[10] = ent(1'b1, 2'd1, 8'd80, 8'd80);
        ram[11] = ent(1'b1, 2'd3, 8'd80, 8'd80);
        run_check(64'h0, 1);

        // Player bullet vs enemy
        ram[3] = ent(1'b1, 2'd1, 8'd50, 8'd50);
        run_check(64'hC, 1);

        // No wrap around 255
        clear_ram();
        ram[62] = ent(1'b1, 2'd0, 8'd250, 8'd10);
        ram[63] = ent(1'b1, 2'd2, 8'd4,   8'd10);
        run_check(64'h0, 1);

        // Last pair hits near the right edge
        ram[63] = ent(1'b1, 2'd2, 8'd240, 8'd10);
        run_check(64'hC000_0000_0000_0000, 1);

        // Second start mid-check is ignored
        exp_q.push_back(64'hC000_0000_0000_0000);
        start_pulse(1);
        repeat (498) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Reset mid-check aborts and clears outputs immediately
        start_pulse(1);
        repeat (999) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check64("abort_hit",  hit, 64'h0);
        check64("abort_busy", {63'd0, busy}, 64'h0);
        check64("abort_done", {63'd0, done}, 64'h0);
        check64("abort_addr", {58'd0, addr}, 64'h0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;

        // Fresh check after reset
        run_check(64'hC000_0000_0000_0000, 1);

        // Player overlapping three enemies, plus a distant enemy bullet
        clear_ram();
        ram[20] = ent(1'b1, 2'd0, 8'd60,  8'd60);
        ram[7]  = ent(1'b1, 2'd2, 8'd70,  8'd70);
        ram[30] = ent(1'b1, 2'd2, 8'd50,  8'd60);
        ram[40] = ent(1'b1, 2'd2, 8'd60,  8'd74);
        ram[41] = ent(1'b1, 2'd3, 8'd200, 8'd200);
        exp_q.push_back(64'h0000_0100_4010_0080);
        start_pulse(1);
        wait_done();

        // Start during the done cycle; previous bitmap must hold until the next done
        clear_ram();
        exp_q.push_back(64'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        check64("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
